// File: rtl/led_p2s_8_if.sv
// led_p2s_8_if: controller-side handshake and serial chain signals of the parallel-to-serial driver
interface led_p2s_8_if #(parameter int DW = 8);
    logic          start;
    logic [DW-1:0] p_data;
    logic          busy;
    logic          done;
    logic          s_clk;
    logic          s_data;
    logic          s_latch;
    logic          s_clrn;
    modport master (output start, p_data, input busy, done, s_clk, s_data, s_latch, s_clrn);
    modport slave  (input start, p_data, output busy, done, s_clk, s_data, s_latch, s_clrn);
endinterface

// File: rtl/led_p2s_8.sv
// led_p2s_8: shifts a captured parallel word into a 74HC595-style chain with divided clock, latch pulse and done
module led_p2s_8 #(
    parameter int DW        = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    led_p2s_8_if.slave  bus
);
    localparam int CW = $clog2(DIV) + 1;
    localparam int BW = $clog2(DW) + 1;
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
    state_t        state;
    logic [DW-1:0] sr;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bc;
    logic          last;
    logic          bit_cur;
    logic [DW-1:0] sr_nx;
    assign last    = cnt == CW'(DIV - 1);
    assign bit_cur = MSB_FIRST ? sr[DW-1] : sr[0];
    assign sr_nx   = MSB_FIRST ? sr << 1 : sr >> 1;
    // Outputs are decoded from the current state, so they trail the state register by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            bc          <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.s_clk   <= 1'b1;
            bus.s_data  <= 1'b0;
            bus.s_latch <= 1'b0;
            bus.s_clrn  <= 1'b0;
        end else begin
            bus.s_clrn  <= 1'b1;
            bus.busy    <= state != IDLE;
            bus.done    <= state == DONE;
            bus.s_clk   <= state != SHIFT_LO;
            bus.s_latch <= state == LATCH;
            if (state == SHIFT_LO) bus.s_data <= bit_cur;
            case (state)
                IDLE: if (bus.start) begin
                    sr    <= bus.p_data;
                    bc    <= '0;
                    cnt   <= '0;
                    state <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) state <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        sr    <= sr_nx;
                        bc    <= bc == BW'(DW - 1) ? bc : bc + BW'(1);
                        state <= bc == BW'(DW - 1) ? LATCH : SHIFT_LO;
                    end
                end
                LATCH: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_p2s_8.sv
// tb_led_p2s_8: directed checks of serial timing, bit order, latch/done pulses and async reset
module tb_led_p2s_8;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  led_p2s_8_if #(.DW(8)) ia ();
  led_p2s_8_if #(.DW(8)) ib ();
  led_p2s_8_if #(.DW(8)) ic ();
  led_p2s_8 #(.DW(8), .DIV(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  led_p2s_8 #(.DW(8), .DIV(2), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  led_p2s_8 #(.DW(8), .DIV(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));
  logic [7:0] capa = 0, capb = 0, capc = 0;
  int         na = 0, nb = 0, nc = 0;
  int         base;
  always @(posedge ia.s_clk) begin capa = {capa[6:0], ia.s_data}; na++; end
  always @(posedge ib.s_clk) begin capb = {capb[6:0], ib.s_data}; nb++; end
  always @(posedge ic.s_clk) begin capc = {capc[6:0], ic.s_data}; nc++; end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_cyc(input string tag, input int n, input int div, input logic [7:0] seq,
                         input logic b, input logic d, input logic c, input logic sd, input logic l);
    int   s  = 16 * div;
    int   t  = s + div + 1;
    logic ce = 1'b1;
    logic le = 1'b0;
    logic de = seq[0];
    if (n >= 1 && n <= s) begin
      ce = ((n - 1) % (2 * div)) >= div;
      de = seq[7 - (n - 1) / (2 * div)];
    end
    if (n > s && n <= s + div) le = 1'b1;
    chk($sformatf("%s busy c%0d", tag, n), b, n >= 1 && n <= t);
    chk($sformatf("%s done c%0d", tag, n), d, n == t);
    chk($sformatf("%s s_clk c%0d", tag, n), c, ce);
    chk($sformatf("%s s_latch c%0d", tag, n), l, le);
    if (n >= 1 && n <= t) chk($sformatf("%s s_data c%0d", tag, n), sd, de);
  endtask
  initial begin
    rst_n = 1'b1;
    ia.start = 0; ia.p_data = 0;
    ib.start = 0; ib.p_data = 0;
    ic.start = 0; ic.p_data = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", ia.busy, 1'b0);
    chk("rst done", ia.done, 1'b0);
    chk("rst s_clk", ia.s_clk, 1'b1);
    chk("rst s_data", ia.s_data, 1'b0);
    chk("rst s_latch", ia.s_latch, 1'b0);
    chk("rst s_clrn", ia.s_clrn, 1'b0);
    chk("rst b s_clk", ib.s_clk, 1'b1);
    chk("rst c s_clrn", ic.s_clrn, 1'b0);
    rst_n = 1'b1;
    #1 chk("clrn before edge", ia.s_clrn, 1'b0);
    @(posedge clk);
    #1;
    chk("clrn after edge", ia.s_clrn, 1'b1);
    chk("idle busy", ia.busy, 1'b0);
    base = na; ia.p_data = 8'hA5; ia.start = 1'b1;
    for (int n = 0; n <= 37; n++) begin
      @(posedge clk); #1;
      if (n == 0) ia.start = 1'b0;
      chk_cyc("a5", n, 2, 8'hA5, ia.busy, ia.done, ia.s_clk, ia.s_data, ia.s_latch);
    end
    chk("a5 captured", capa, 8'hA5);
    chk("a5 edges", na - base, 8);
    base = nb; ib.p_data = 8'h01; ib.start = 1'b1;
    for (int n = 0; n <= 37; n++) begin
      @(posedge clk); #1;
      if (n == 0) ib.start = 1'b0;
      if (n == 3) ib.p_data = 8'hFF;
      chk_cyc("lsb01", n, 2, 8'h80, ib.busy, ib.done, ib.s_clk, ib.s_data, ib.s_latch);
    end
    chk("lsb01 captured", capb, 8'h80);
    chk("lsb01 edges", nb - base, 8);
    base = na; ia.p_data = 8'h3C; ia.start = 1'b1;
    for (int n = 0; n <= 72; n++) begin
      @(posedge clk); #1;
      chk_cyc("held", n % 36, 2, 8'h3C, ia.busy, ia.done, ia.s_clk, ia.s_data, ia.s_latch);
      if (n == 71) ia.start = 1'b0;
    end
    for (int n = 73; n <= 75; n++) begin
      @(posedge clk); #1;
      chk($sformatf("held idle busy c%0d", n), ia.busy, 1'b0);
    end
    chk("held captured", capa, 8'h3C);
    chk("held edges", na - base, 16);
    ia.p_data = 8'h5A; ia.start = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 0) ia.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", ia.busy, 1'b0);
    chk("mid rst s_clk", ia.s_clk, 1'b1);
    chk("mid rst s_data", ia.s_data, 1'b0);
    chk("mid rst s_clrn", ia.s_clrn, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("mid rst s_latch", ia.s_latch, 1'b0);
      chk("mid rst done", ia.done, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid rst clrn back", ia.s_clrn, 1'b1);
    base = na; ia.p_data = 8'hC3; ia.start = 1'b1;
    for (int n = 0; n <= 37; n++) begin
      @(posedge clk); #1;
      if (n == 0) ia.start = 1'b0;
      chk_cyc("c3", n, 2, 8'hC3, ia.busy, ia.done, ia.s_clk, ia.s_data, ia.s_latch);
    end
    chk("c3 captured", capa, 8'hC3);
    chk("c3 edges", na - base, 8);
    base = nc; ic.p_data = 8'hFF; ic.start = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 0) ic.start = 1'b0;
      chk_cyc("div1", n, 1, 8'hFF, ic.busy, ic.done, ic.s_clk, ic.s_data, ic.s_latch);
    end
    chk("div1 captured", capc, 8'hFF);
    chk("div1 edges", nc - base, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
